adc_spi_cfg_slave: RTL and testbench

SPI responder that terminates the 16-bit ADC configuration frames issued by the housekeeping SPI master: 8-bit address byte followed by 8-bit data byte. It samples the SPI pins in the `clk_i` domain and decodes frames into a small register file. It exports the register contents and write strobes to the ADC behavioural model and to the daisy-chain loopback path. It also supports readback on MISO so the master's read mode can be exercised.

---
 rtl/adc_spi_pkg.sv | 22 ++
 rtl/spi_sync_edge.sv | 39 +++
 rtl/adc_spi_cfg_slave.sv | 162 ++++++++++++++++
 tb/tb_adc_spi_cfg_slave.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// Shared constants and FSM encoding for the ADC configuration SPI responder.
package adc_spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_BITS  = 7;
  localparam int DATA_BITS  = 8;
  localparam int RW_BIT     = 15;

  // ADC register map
  localparam logic [ADDR_BITS-1:0] PDWN = 7'd1;
  localparam logic [ADDR_BITS-1:0] TIM  = 7'd2;
  localparam logic [ADDR_BITS-1:0] MODE = 7'd3;
  localparam logic [ADDR_BITS-1:0] FORM = 7'd4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ADDR     = 2'd1,
    DATA     = 2'd2,
    WAIT_END = 2'd3
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Single-pin synchronizer with registered rise/fall pulses.
// lvl_o is the delayed level, time-aligned with the edge pulses.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT        = 1'b0
) (
  input  logic clk_i,
  input  logic pll_ff_rst,
  input  logic pin_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   dly_p1;
  logic                   rise_p1;
  logic                   fall_p1;

  // Metastability chain, then one flop to compare against for edge detection
  always_ff @(posedge clk_i or negedge pll_ff_rst) begin
    if (!pll_ff_rst) begin
      sync_p0 <= {SYNC_STAGES{INIT}};
      dly_p1  <= INIT;
      rise_p1 <= 1'b0;
      fall_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pin_i};
      dly_p1  <= sync_p0[SYNC_STAGES-1];
      rise_p1 <= sync_p0[SYNC_STAGES-1] & ~dly_p1;
      fall_p1 <= ~sync_p0[SYNC_STAGES-1] & dly_p1;
    end
  end

  assign lvl_o  = dly_p1;
  assign rise_o = rise_p1;
  assign fall_o = fall_p1;

endmodule

// File: rtl/adc_spi_cfg_slave.sv
// SPI responder for 16-bit ADC configuration frames (R/W + 7-bit address + 8-bit data).
// Decodes frames into a small register file and supports readback on MISO.
module adc_spi_cfg_slave
  import adc_spi_pkg::*;
#(
  parameter int                NREG        = 8,
  parameter logic [NREG*8-1:0] REG_INIT    = '0,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              pll_ff_rst,
  input  logic              spi_cs_i,
  input  logic              spi_clk_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_t,
  output logic [NREG*8-1:0] reg_o,
  output logic              wr_stb_o,
  output logic [6:0]        wr_adr_o,
  output logic [7:0]        wr_dat_o,
  output logic              frame_err_o,
  output logic [15:0]       frame_cnt_o
);

  localparam logic [4:0] CNT_ADDR  = 5'(ADDR_BITS + 1);
  localparam logic [4:0] CNT_FRAME = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_DATA0 = 5'(ADDR_BITS + 2);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_edges;

  // CS chain starts "low" so a CS already held low at reset release shows no edge
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_cs (
    .clk_i(clk_i), .pll_ff_rst(pll_ff_rst), .pin_i(spi_cs_i),
    .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_sck (
    .clk_i(clk_i), .pll_ff_rst(pll_ff_rst), .pin_i(spi_clk_i),
    .lvl_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
    .clk_i(clk_i), .pll_ff_rst(pll_ff_rst), .pin_i(spi_mosi_i),
    .lvl_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

  assign unused_edges = &{1'b0, sck_lvl, mosi_rise, mosi_fall};

  state_e            state_q;
  logic [4:0]        bit_cnt_q;
  logic [15:0]       sh_in_q;
  logic [7:0]        sh_out_q;
  logic              rw_q;
  logic              cs_armed_q;
  logic [NREG*8-1:0] reg_q;

  logic              sck_rise_act;
  logic [4:0]        cnt_nxt;
  logic [15:0]       sh_nxt;
  logic [6:0]        rd_adr;
  logic [7:0]        rd_dat;
  logic [6:0]        fr_adr;
  logic              fr_hit;

  // Next bit count / shift value, so a bit coinciding with CS rise is counted before commit
  always_comb begin
    sck_rise_act = sck_rise && (state_q != IDLE);
    cnt_nxt      = bit_cnt_q;
    sh_nxt       = sh_in_q;
    if (sck_rise_act) begin
      sh_nxt = {sh_in_q[14:0], mosi_lvl};
      if (bit_cnt_q <= CNT_FRAME) cnt_nxt = bit_cnt_q + 5'd1;
    end
    rd_adr = sh_nxt[6:0];
    rd_dat = 8'h00;
    if (int'(rd_adr) < NREG) rd_dat = reg_q[int'(rd_adr)*8 +: 8];
    fr_adr = sh_nxt[14:8];
    fr_hit = (int'(fr_adr) < NREG);
  end

  // Frame FSM, readback shifter and register-file commit
  always_ff @(posedge clk_i or negedge pll_ff_rst) begin
    if (!pll_ff_rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sh_in_q     <= '0;
      sh_out_q    <= '0;
      rw_q        <= 1'b0;
      cs_armed_q  <= 1'b0;
      reg_q       <= REG_INIT;
      wr_stb_o    <= 1'b0;
      wr_adr_o    <= '0;
      wr_dat_o    <= '0;
      frame_err_o <= 1'b0;
      frame_cnt_o <= '0;
      spi_miso_o  <= 1'b0;
      spi_miso_t  <= 1'b1;
    end else begin
      wr_stb_o    <= 1'b0;
      frame_err_o <= 1'b0;
      if (cs_lvl) cs_armed_q <= 1'b1;
      if (cs_rise) begin
        state_q    <= IDLE;
        spi_miso_t <= 1'b1;
        if (state_q != IDLE) begin
          if (cnt_nxt == CNT_FRAME) begin
            frame_cnt_o <= frame_cnt_o + 16'd1;
            if (!sh_nxt[RW_BIT] && fr_hit) begin
              reg_q[int'(fr_adr)*8 +: 8] <= sh_nxt[7:0];
              wr_stb_o <= 1'b1;
              wr_adr_o <= fr_adr;
              wr_dat_o <= sh_nxt[7:0];
            end
          end else begin
            frame_err_o <= 1'b1;
          end
        end
      end else begin
        case (state_q)
          IDLE: begin
            spi_miso_t <= 1'b1;
            if (cs_fall && cs_armed_q) begin
              state_q   <= ADDR;
              bit_cnt_q <= '0;
            end
          end
          ADDR: begin
            bit_cnt_q <= cnt_nxt;
            sh_in_q   <= sh_nxt;
            if (sck_rise_act && cnt_nxt == CNT_ADDR) begin
              state_q <= DATA;
              rw_q    <= sh_nxt[7];
              if (sh_nxt[7]) begin
                spi_miso_t <= 1'b0;
                spi_miso_o <= rd_dat[7];
                sh_out_q   <= {rd_dat[6:0], 1'b0};
              end
            end
          end
          DATA: begin
            bit_cnt_q <= cnt_nxt;
            sh_in_q   <= sh_nxt;
            // MSB stays on the pin through the first data sample edge
            if (sck_fall && rw_q && bit_cnt_q >= CNT_DATA0) begin
              spi_miso_o <= sh_out_q[7];
              sh_out_q   <= {sh_out_q[6:0], 1'b0};
            end
            if (sck_rise_act && cnt_nxt == CNT_FRAME) state_q <= WAIT_END;
          end
          WAIT_END: begin
            bit_cnt_q <= cnt_nxt;
            sh_in_q   <= sh_nxt;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign reg_o = reg_q;

endmodule

// File: tb/tb_adc_spi_cfg_slave.sv
// Self-checking bench for adc_spi_cfg_slave: directed frames plus randomized frames
// checked against a frame-level register-file model.
module tb_adc_spi_cfg_slave;

  localparam int          NREG = 8;
  localparam logic [63:0] INIT = 64'h0123_4567_89AB_CDEF;
  localparam int          H    = 8;

  logic        clk_i = 1'b0;
  logic        pll_ff_rst = 1'b0;
  logic        spi_cs_i = 1'b1;
  logic        spi_clk_i = 1'b1;
  logic        spi_mosi_i = 1'b0;
  logic        spi_miso_o;
  logic        spi_miso_t;
  logic [63:0] reg_o;
  logic        wr_stb_o;
  logic [6:0]  wr_adr_o;
  logic [7:0]  wr_dat_o;
  logic        frame_err_o;
  logic [15:0] frame_cnt_o;

  adc_spi_cfg_slave #(.NREG(NREG), .REG_INIT(INIT), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .pll_ff_rst(pll_ff_rst),
    .spi_cs_i(spi_cs_i), .spi_clk_i(spi_clk_i), .spi_mosi_i(spi_mosi_i),
    .spi_miso_o(spi_miso_o), .spi_miso_t(spi_miso_t), .reg_o(reg_o),
    .wr_stb_o(wr_stb_o), .wr_adr_o(wr_adr_o), .wr_dat_o(wr_dat_o),
    .frame_err_o(frame_err_o), .frame_cnt_o(frame_cnt_o));

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // pulse monitors
  int stb_cnt = 0, err_cnt = 0, stb_dbl = 0, err_dbl = 0;
  logic stb_prev = 1'b0, err_prev = 1'b0;
  always @(negedge clk_i) begin
    if (wr_stb_o) stb_cnt <= stb_cnt + 1;
    if (frame_err_o) err_cnt <= err_cnt + 1;
    if (wr_stb_o && stb_prev) stb_dbl <= stb_dbl + 1;
    if (frame_err_o && err_prev) err_dbl <= err_dbl + 1;
    stb_prev <= wr_stb_o;
    err_prev <= frame_err_o;
  end

  // reference model
  logic [7:0]  m_reg [NREG];
  int          m_cnt, m_stb, m_err;
  logic [6:0]  m_adr;
  logic [7:0]  m_dat;

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) m_reg[k] = INIT[8*k +: 8];
    m_cnt = 0; m_adr = '0; m_dat = '0;
  endtask

  function automatic logic [63:0] model_pack();
    logic [63:0] v;
    for (int k = 0; k < NREG; k++) v[8*k +: 8] = m_reg[k];
    return v;
  endfunction

  function automatic logic [7:0] model_read(input int a);
    return (a < NREG) ? m_reg[a] : 8'h00;
  endfunction

  task automatic model_frame(input logic [15:0] w, input int nbits);
    int a;
    a = int'(w[14:8]);
    if (nbits == 16) begin
      m_cnt = (m_cnt + 1) % 65536;
      if (!w[15] && a < NREG) begin
        m_reg[a] = w[7:0]; m_adr = w[14:8]; m_dat = w[7:0]; m_stb++;
      end
    end else begin
      m_err++;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // toggle SCLK for nbits bits without touching CS; samples MISO at data rises
  task automatic clock_bits(input logic [15:0] w, input int nbits,
                            output logic [7:0] rb, output int tri_bad);
    rb = 8'h00; tri_bad = 0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_i);
      spi_clk_i  = 1'b0;
      spi_mosi_i = (i < 16) ? w[15-i] : 1'b1;
      repeat (H) @(negedge clk_i);
      if (i >= 8 && i < 16) begin
        rb[15-i] = spi_miso_o;
        if (spi_miso_t !== 1'b0) tri_bad++;
      end
      spi_clk_i = 1'b1;
      repeat (H - 1) @(negedge clk_i);
    end
  endtask

  task automatic frame(input logic [15:0] w, input int nbits, output logic [7:0] rb,
                       output int tri_bad);
    @(negedge clk_i);
    spi_cs_i = 1'b0;
    repeat (H) @(negedge clk_i);
    clock_bits(w, nbits, rb, tri_bad);
    repeat (H) @(negedge clk_i);
    spi_cs_i = 1'b1;
    repeat (12) @(negedge clk_i);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] w, input int nbits);
    logic [7:0] rb;
    int         tri_bad;
    logic [7:0] exp_rb;
    exp_rb = model_read(int'(w[14:8]));
    frame(w, nbits, rb, tri_bad);
    model_frame(w, nbits);
    if (w[15] && nbits == 16) begin
      chk({tag, ".miso"}, 64'(rb), 64'(exp_rb));
      chk({tag, ".tri_in"}, 64'(tri_bad), 64'd0);
    end
    chk({tag, ".reg"}, reg_o, model_pack());
    chk({tag, ".cnt"}, 64'(frame_cnt_o), 64'(m_cnt));
    chk({tag, ".stb"}, 64'(stb_cnt), 64'(m_stb));
    chk({tag, ".err"}, 64'(err_cnt), 64'(m_err));
    chk({tag, ".adr"}, 64'(wr_adr_o), 64'(m_adr));
    chk({tag, ".dat"}, 64'(wr_dat_o), 64'(m_dat));
    chk({tag, ".tri_out"}, 64'(spi_miso_t), 64'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    int         tri_bad, kind, nb;
    logic [15:0] w;
    m_stb = 0; m_err = 0;
    model_reset();
    repeat (4) @(negedge clk_i);
    chk("rst.reg", reg_o, INIT);
    chk("rst.tri", 64'(spi_miso_t), 64'd1);
    chk("rst.miso", 64'(spi_miso_o), 64'd0);
    chk("rst.cnt", 64'(frame_cnt_o), 64'd0);
    chk("rst.stb", 64'(wr_stb_o), 64'd0);
    chk("rst.err", 64'(frame_err_o), 64'd0);
    pll_ff_rst = 1'b1;
    repeat (10) @(negedge clk_i);

    run_frame("wr02", 16'h0201, 16);
    run_frame("init1", 16'h0100, 16);
    run_frame("init2", 16'h0201, 16);
    run_frame("init3", 16'h0302, 16);
    run_frame("init4", 16'h0400, 16);
    run_frame("rd83", 16'h8300, 16);
    run_frame("abort11", 16'h05AA, 11);
    run_frame("good", 16'h0533, 16);
    run_frame("over17", 16'h0644, 17);
    run_frame("wr7f", 16'h7F55, 16);
    run_frame("rdff", 16'hFF00, 16);
    chk("stb_single", 64'(stb_dbl), 64'd0);
    chk("err_single", 64'(err_dbl), 64'd0);

    // reset mid-frame with CS held low through release
    @(negedge clk_i);
    spi_cs_i = 1'b0;
    repeat (H) @(negedge clk_i);
    clock_bits(16'h03AA, 6, rb, tri_bad);
    pll_ff_rst = 1'b0;
    model_reset();
    #1;
    chk("midrst.reg", reg_o, INIT);
    chk("midrst.cnt", 64'(frame_cnt_o), 64'd0);
    repeat (3) @(negedge clk_i);
    pll_ff_rst = 1'b1;
    clock_bits(16'h0366, 16, rb, tri_bad);
    repeat (H) @(negedge clk_i);
    spi_cs_i = 1'b1;
    repeat (12) @(negedge clk_i);
    chk("midrst.ign_reg", reg_o, INIT);
    chk("midrst.ign_cnt", 64'(frame_cnt_o), 64'd0);
    chk("midrst.ign_stb", 64'(stb_cnt), 64'(m_stb));
    chk("midrst.ign_err", 64'(err_cnt), 64'(m_err));
    run_frame("after_rst", 16'h0377, 16);

    // randomized frames
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      w    = 16'($urandom);
      nb   = 16;
      case (kind)
        0, 1, 2, 3: w[15:8] = 8'($urandom_range(0, NREG - 1));
        4:          w[15:8] = 8'($urandom_range(NREG, 127));
        5, 6:       w[15] = 1'b1;
        7:          nb = $urandom_range(1, 15);
        8:          nb = $urandom_range(17, 19);
        default:    w[15:8] = 8'(8'h80 | 8'($urandom_range(0, NREG - 1)));
      endcase
      run_frame("rand", w, nb);
    end
    chk("stb_single_end", 64'(stb_dbl), 64'd0);
    chk("err_single_end", 64'(err_dbl), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
